// File: rtl/audio_sample_sequencer.sv
// Paces codec ADC samples through the FIR stage and back to the DAC, one filter step per sample.
// Optional DAC stall counter enabled by defining AUDIO_SEQ_STALL_CNT_EN.
module audio_sample_sequencer #(
    parameter int WIDTH   = 24,
    parameter int LATENCY = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             read_ready,
    input  logic [WIDTH-1:0] readdata_left,
    input  logic [WIDTH-1:0] readdata_right,
    output logic             read,
    output logic [WIDTH-1:0] filt_in_left,
    output logic [WIDTH-1:0] filt_in_right,
    output logic             filt_step,
    input  logic [WIDTH-1:0] filt_out_left,
    input  logic [WIDTH-1:0] filt_out_right,
    input  logic             write_ready,
    output logic [WIDTH-1:0] writedata_left,
    output logic [WIDTH-1:0] writedata_right,
    output logic             write,
    output logic [15:0]      sample_count,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        WAIT,
        WRITE_WAIT
    } state_t;

    state_t     state;
    logic [4:0] wait_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            read            <= 1'b0;
            filt_step       <= 1'b0;
            write           <= 1'b0;
            filt_in_left    <= '0;
            filt_in_right   <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            wait_cnt        <= '0;
            sample_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write <= 1'b0;
                    if (read_ready) begin
                        filt_in_left  <= readdata_left;
                        filt_in_right <= readdata_right;
                        read          <= 1'b1;
                        state         <= STEP;
                    end
                end
                STEP: begin
                    read      <= 1'b0;
                    filt_step <= 1'b1;
                    // Filter taps advance on the edge after the step cycle, so the
                    // result is captured LATENCY+1 edges after entering WAIT.
                    wait_cnt  <= 5'(LATENCY + 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    filt_step <= 1'b0;
                    if (wait_cnt == 5'd1) begin
                        writedata_left  <= filt_out_left;
                        writedata_right <= filt_out_right;
                        state           <= WRITE_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt - 5'd1;
                    end
                end
                WRITE_WAIT: begin
                    if (write_ready) begin
                        write        <= 1'b1;
                        sample_count <= sample_count + 16'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AUDIO_SEQ_STALL_CNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_count <= '0;
        end else if (state == WRITE_WAIT && !write_ready && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule
